// File: rtl/dispatch_pkg.sv
// Shared opcodes, response codes, engine command encodings and FSM states
// for the command dispatcher.
package dispatch_pkg;

    localparam logic [7:0] OP_DATA    = 8'h00;
    localparam logic [7:0] OP_START   = 8'h01;
    localparam logic [7:0] OP_STOP    = 8'h02;
    localparam logic [7:0] OP_AUX_LO  = 8'h10;
    localparam logic [7:0] OP_AUX_HI  = 8'h11;
    localparam logic [7:0] OP_AUX_HIZ = 8'h12;
    localparam logic [7:0] OP_AUX_RD  = 8'h13;
    localparam logic [7:0] OP_DELAY   = 8'h20;

    localparam logic [7:0] RSP_ERR_OP  = 8'hFF;
    localparam logic [7:0] RSP_TIMEOUT = 8'hFE;

    localparam logic [1:0] ENG_DATA  = 2'd0;
    localparam logic [1:0] ENG_START = 2'd1;
    localparam logic [1:0] ENG_STOP  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_EXEC, S_ENG_WAIT, S_DELAY, S_RESP
    } state_t;

    function automatic logic [1:0] eng_cmd_of(input logic [7:0] op);
        case (op)
            OP_START: eng_cmd_of = ENG_START;
            OP_STOP:  eng_cmd_of = ENG_STOP;
            default:  eng_cmd_of = ENG_DATA;
        endcase
    endfunction

endpackage

// File: rtl/dispatch_timer.sv
// Loadable down-counter with zero flag; shared by delay and engine timeout.
module dispatch_timer #(
    parameter int W = 9
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/dispatch_engine.sv
// Command dispatcher: pops {opcode,data} words, drives the protocol engine,
// AUX pins and delays locally, and pushes response words.
module dispatch_engine
    import dispatch_pkg::*;
#(
    parameter int AUX_N       = 4,
    parameter int DELAY_SHIFT = 0,
    parameter int TIMEOUT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_fifo_out_nempty,
    input  logic [15:0]      in_fifo_out_data,
    output logic             in_fifo_out_pop,
    input  logic             out_fifo_in_full,
    output logic             out_fifo_in_shift,
    output logic [15:0]      out_fifo_in_data,
    output logic             eng_go,
    output logic [1:0]       eng_cmd,
    output logic [7:0]       eng_wdata,
    input  logic [7:0]       eng_rdata,
    input  logic             eng_done,
    output logic [AUX_N-1:0] aux_out,
    output logic [AUX_N-1:0] aux_oe,
    input  logic [AUX_N-1:0] aux_in,
    output logic             busy,
    output logic             error
);
    localparam int TMR_W = (9 + DELAY_SHIFT > TIMEOUT_W + 1) ? 9 + DELAY_SHIFT : TIMEOUT_W + 1;
    localparam int RD_N  = (AUX_N < 8) ? AUX_N : 8;
    localparam logic [4:0]       AUX_LIM  = 5'(AUX_N);
    localparam logic [TMR_W-1:0] TMO_LOAD = (TMR_W'(1) << TIMEOUT_W) - TMR_W'(1);

    state_t             state, state_d;
    logic [7:0]         op_q, op_d, dat_q, dat_d;
    logic [15:0]        resp_q, resp_d;
    logic [AUX_N-1:0]   aout_q, aout_d, aoe_q, aoe_d;
    logic               err_q, err_d;
    logic               tmr_load, tmr_dec, tmr_zero;
    logic [TMR_W-1:0]   tmr_val, dly_load;
    logic [7:0]         aux_rd;
    logic               pin_ok, go, bad;

    dispatch_timer #(.W(TMR_W)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    assign dly_load = ((TMR_W'(dat_q) + TMR_W'(1)) << DELAY_SHIFT) - TMR_W'(1);
    assign pin_ok   = {1'b0, dat_q[3:0]} < AUX_LIM;

    always_comb begin
        aux_rd = '0;
        for (int i = 0; i < RD_N; i++) aux_rd[i] = aux_in[i];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_IDLE;
            op_q   <= '0;
            dat_q  <= '0;
            resp_q <= '0;
            aout_q <= '0;
            aoe_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_d;
            op_q   <= op_d;
            dat_q  <= dat_d;
            resp_q <= resp_d;
            aout_q <= aout_d;
            aoe_q  <= aoe_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        state_d  = state;
        op_d     = op_q;
        dat_d    = dat_q;
        resp_d   = resp_q;
        aout_d   = aout_q;
        aoe_d    = aoe_q;
        err_d    = err_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;
        go       = 1'b0;
        bad      = 1'b0;
        case (state)
            S_IDLE: if (in_fifo_out_nempty) state_d = S_FETCH;
            S_FETCH: begin
                op_d    = in_fifo_out_data[15:8];
                dat_d   = in_fifo_out_data[7:0];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (op_q)
                    OP_DATA, OP_START, OP_STOP: begin
                        go       = 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = TMO_LOAD;
                        state_d  = S_ENG_WAIT;
                    end
                    OP_AUX_LO, OP_AUX_HI, OP_AUX_HIZ: begin
                        if (!pin_ok) bad = 1'b1;
                        else begin
                            for (int i = 0; i < AUX_N; i++) begin
                                if (dat_q[3:0] == 4'(i)) begin
                                    aoe_d[i] = (op_q != OP_AUX_HIZ);
                                    if (op_q != OP_AUX_HIZ) aout_d[i] = (op_q == OP_AUX_HI);
                                end
                            end
                            state_d = S_IDLE;
                        end
                    end
                    OP_AUX_RD: begin
                        if (!pin_ok) bad = 1'b1;
                        else begin
                            resp_d  = {OP_AUX_RD, aux_rd};
                            state_d = S_RESP;
                        end
                    end
                    OP_DELAY: begin
                        tmr_load = 1'b1;
                        tmr_val  = dly_load;
                        state_d  = S_DELAY;
                    end
                    default: bad = 1'b1;
                endcase
                // Bad opcode/pin leaves AUX state untouched: only the response path is taken.
                if (bad) begin
                    resp_d  = {RSP_ERR_OP, op_q};
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_ENG_WAIT: begin
                if (eng_done) begin
                    if (op_q == OP_DATA) begin
                        resp_d  = {OP_DATA, eng_rdata};
                        state_d = S_RESP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (tmr_zero) begin
                    resp_d  = {RSP_TIMEOUT, 8'h00};
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            S_DELAY: begin
                if (tmr_zero) state_d = S_IDLE;
                else          tmr_dec = 1'b1;
            end
            S_RESP: if (!out_fifo_in_full) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are gated by reset so an abandoned command never pops or pushes.
    assign in_fifo_out_pop   = !reset && (state == S_FETCH);
    assign out_fifo_in_shift = !reset && (state == S_RESP) && !out_fifo_in_full;
    assign eng_go            = !reset && go;
    assign eng_cmd           = eng_cmd_of(op_q);
    assign eng_wdata         = dat_q;
    assign out_fifo_in_data  = resp_q;
    assign aux_out           = aout_q;
    assign aux_oe            = aoe_q;
    assign busy              = (state != S_IDLE);
    assign error             = err_q;
endmodule

// File: tb/tb_dispatch_engine.sv
// Directed bench: vector table for single commands plus hand sequences for
// pop spacing, output-full stall and reset mid-delay.
module tb_dispatch_engine;
    logic        clock = 1'b0;
    logic        reset;
    logic        in_fifo_out_nempty;
    logic [15:0] in_fifo_out_data;
    logic        in_fifo_out_pop;
    logic        out_fifo_in_full;
    logic        out_fifo_in_shift;
    logic [15:0] out_fifo_in_data;
    logic        eng_go;
    logic [1:0]  eng_cmd;
    logic [7:0]  eng_wdata;
    logic [7:0]  eng_rdata;
    logic        eng_done;
    logic [3:0]  aux_out, aux_oe, aux_in;
    logic        busy, error;

    dispatch_engine #(.AUX_N(4), .DELAY_SHIFT(0), .TIMEOUT_W(4)) dut (
        .clock(clock), .reset(reset),
        .in_fifo_out_nempty(in_fifo_out_nempty), .in_fifo_out_data(in_fifo_out_data),
        .in_fifo_out_pop(in_fifo_out_pop),
        .out_fifo_in_full(out_fifo_in_full), .out_fifo_in_shift(out_fifo_in_shift),
        .out_fifo_in_data(out_fifo_in_data),
        .eng_go(eng_go), .eng_cmd(eng_cmd), .eng_wdata(eng_wdata),
        .eng_rdata(eng_rdata), .eng_done(eng_done),
        .aux_out(aux_out), .aux_oe(aux_oe), .aux_in(aux_in),
        .busy(busy), .error(error)
    );

    always #5 clock = ~clock;

    int total = 0, bad = 0;
    int cyc = 0, busy_cnt = 0, pop_cnt = 0, push_cnt = 0, bad_push = 0, dbl_pop = 0;
    int last_pop = 0, prev_pop = 0, go_cnt = 0;
    logic        pop_prev = 1'b0;
    logic [15:0] last_push = '0;
    logic [1:0]  last_cmd = '0;
    logic [7:0]  last_wd = '0;
    int eng_lat = 0, eng_cnt = 0;
    logic [7:0] eng_ret = '0;

    always @(negedge clock) begin
        cyc++;
        if (busy) busy_cnt++;
        if (in_fifo_out_pop) begin
            pop_cnt++;
            prev_pop = last_pop;
            last_pop = cyc;
            if (pop_prev) dbl_pop++;
        end
        pop_prev = in_fifo_out_pop;
        if (out_fifo_in_shift) begin
            push_cnt++;
            last_push = out_fifo_in_data;
            if (out_fifo_in_full) bad_push++;
        end
    end

    // Engine model: done strobe eng_lat cycles after go; eng_lat==0 never answers.
    always @(negedge clock) begin
        eng_done = 1'b0;
        if (eng_go) begin
            go_cnt++;
            last_cmd = eng_cmd;
            last_wd  = eng_wdata;
            eng_cnt  = eng_lat;
        end else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                eng_done  = 1'b1;
                eng_rdata = eng_ret;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_pop(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (in_fifo_out_pop) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (!busy) begin ok = 1'b1; break; end
        end
        #1;
    endtask

    typedef struct {
        logic [15:0] word;
        logic [3:0]  ain;
        int          lat;
        logic [7:0]  ret;
        int          npush;
        logic [15:0] resp;
        logic [3:0]  aout, aoe;
        logic        err;
        int          bsy;
        int          ngo;
        logic [1:0]  cmd;
        logic [7:0]  wd;
    } vec_t;

    vec_t vt[16];

    task automatic run_vec(input int n, input vec_t v);
        int p0, s0, b0, g0;
        bit ok;
        aux_in  = v.ain;
        eng_lat = v.lat;
        eng_ret = v.ret;
        @(posedge clock); #1;
        in_fifo_out_data   = v.word;
        in_fifo_out_nempty = 1'b1;
        p0 = pop_cnt; s0 = push_cnt; b0 = busy_cnt; g0 = go_cnt;
        wait_pop(ok);
        chk($sformatf("v%0d_pop_seen", n), 32'(ok), 1);
        @(posedge clock); #1;
        in_fifo_out_nempty = 1'b0;
        wait_idle(ok);
        chk($sformatf("v%0d_idle", n), 32'(ok), 1);
        chk($sformatf("v%0d_pops", n), pop_cnt - p0, 1);
        chk($sformatf("v%0d_pushes", n), push_cnt - s0, v.npush);
        if (v.npush > 0) chk($sformatf("v%0d_resp", n), last_push, v.resp);
        chk($sformatf("v%0d_aux_out", n), aux_out, v.aout);
        chk($sformatf("v%0d_aux_oe", n), aux_oe, v.aoe);
        chk($sformatf("v%0d_error", n), error, v.err);
        chk($sformatf("v%0d_busy_cycles", n), busy_cnt - b0, v.bsy);
        chk($sformatf("v%0d_go", n), go_cnt - g0, v.ngo);
        if (v.ngo > 0) begin
            chk($sformatf("v%0d_cmd", n), last_cmd, v.cmd);
            chk($sformatf("v%0d_wdata", n), last_wd, v.wd);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p0, s0;
        bit ok;
        //          word      ain   lat ret   np resp      aout     aoe     err bsy go cmd wd
        vt[0]  = '{16'h1103, 4'h0, 0, 8'h00, 0, 16'h0000, 4'b1100, 4'b1101, 0, 2, 0, 0, 8'h00};
        vt[1]  = '{16'h1202, 4'h0, 0, 8'h00, 0, 16'h0000, 4'b1100, 4'b1001, 0, 2, 0, 0, 8'h00};
        vt[2]  = '{16'h1101, 4'h0, 0, 8'h00, 0, 16'h0000, 4'b1110, 4'b1011, 0, 2, 0, 0, 8'h00};
        vt[3]  = '{16'h2004, 4'h0, 0, 8'h00, 0, 16'h0000, 4'b1110, 4'b1011, 0, 7, 0, 0, 8'h00};
        vt[4]  = '{16'h2000, 4'h0, 0, 8'h00, 0, 16'h0000, 4'b1110, 4'b1011, 0, 3, 0, 0, 8'h00};
        vt[5]  = '{16'h00A5, 4'h0, 7, 8'h3C, 1, 16'h003C, 4'b1110, 4'b1011, 0, 10, 1, 0, 8'hA5};
        vt[6]  = '{16'h0100, 4'h0, 3, 8'h77, 0, 16'h0000, 4'b1110, 4'b1011, 0, 5, 1, 1, 8'h00};
        vt[7]  = '{16'h0255, 4'h0, 2, 8'h77, 0, 16'h0000, 4'b1110, 4'b1011, 0, 4, 1, 2, 8'h55};
        vt[8]  = '{16'h1300, 4'hA, 0, 8'h00, 1, 16'h130A, 4'b1110, 4'b1011, 0, 3, 0, 0, 8'h00};
        vt[9]  = '{16'h7F55, 4'h0, 0, 8'h00, 1, 16'hFF7F, 4'b1110, 4'b1011, 1, 3, 0, 0, 8'h00};
        vt[10] = '{16'h1209, 4'h0, 0, 8'h00, 1, 16'hFF12, 4'b1110, 4'b1011, 1, 3, 0, 0, 8'h00};
        vt[11] = '{16'h1005, 4'h0, 0, 8'h00, 1, 16'hFF10, 4'b1110, 4'b1011, 1, 3, 0, 0, 8'h00};
        vt[12] = '{16'h0011, 4'h0, 0, 8'h00, 1, 16'hFE00, 4'b1110, 4'b1011, 1, 19, 1, 0, 8'h11};
        vt[13] = '{16'h0100, 4'h0, 20, 8'h66, 1, 16'hFE00, 4'b1110, 4'b1011, 1, 19, 1, 1, 8'h00};
        vt[14] = '{16'h1301, 4'h5, 0, 8'h00, 1, 16'h1305, 4'b1110, 4'b1011, 1, 3, 0, 0, 8'h00};
        vt[15] = '{16'h00C3, 4'h0, 1, 8'h99, 1, 16'h0099, 4'b1110, 4'b1011, 1, 4, 1, 0, 8'hC3};

        reset = 1'b1;
        in_fifo_out_nempty = 1'b0;
        in_fifo_out_data   = '0;
        out_fifo_in_full   = 1'b0;
        aux_in    = '0;
        eng_done  = 1'b0;
        eng_rdata = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_aux_oe", aux_oe, 0);
        chk("rst_aux_out", aux_out, 0);
        chk("rst_error", error, 0);
        chk("rst_pop", in_fifo_out_pop, 0);
        chk("rst_shift", out_fifo_in_shift, 0);
        chk("rst_go", eng_go, 0);

        // Back-to-back AUX words: pops one cycle wide, three cycles apart.
        @(posedge clock); #1;
        p0 = pop_cnt; s0 = push_cnt;
        in_fifo_out_data = 16'h1102; in_fifo_out_nempty = 1'b1;
        wait_pop(ok);
        chk("b2b_pop1", 32'(ok), 1);
        @(posedge clock); #1 in_fifo_out_data = 16'h1000;
        wait_pop(ok);
        chk("b2b_pop2", 32'(ok), 1);
        @(posedge clock); #1 in_fifo_out_nempty = 1'b0;
        wait_idle(ok);
        chk("b2b_idle", 32'(ok), 1);
        chk("b2b_pop_gap", last_pop - prev_pop, 3);
        chk("b2b_pops", pop_cnt - p0, 2);
        chk("b2b_wide_pop", dbl_pop, 0);
        chk("b2b_pushes", push_cnt - s0, 0);
        chk("b2b_aux_out", aux_out, 4'b0100);
        chk("b2b_aux_oe", aux_oe, 4'b0101);

        for (int i = 0; i < 16; i++) run_vec(i, vt[i]);

        // Response stalls under full; no pop of the waiting next word.
        aux_in = 4'b1010;
        @(posedge clock); #1;
        out_fifo_in_full = 1'b1;
        p0 = pop_cnt; s0 = push_cnt;
        in_fifo_out_data = 16'h1300; in_fifo_out_nempty = 1'b1;
        wait_pop(ok);
        chk("full_pop1", 32'(ok), 1);
        @(posedge clock); #1 in_fifo_out_data = 16'h1100;
        repeat (10) @(negedge clock);
        #1;
        chk("full_pops_stalled", pop_cnt - p0, 1);
        chk("full_no_push", push_cnt - s0, 0);
        chk("full_busy", busy, 1);
        @(posedge clock); #1 out_fifo_in_full = 1'b0;
        @(negedge clock); #1;
        chk("full_push_once", push_cnt - s0, 1);
        chk("full_resp", last_push, 16'h130A);
        wait_pop(ok);
        chk("full_pop2", 32'(ok), 1);
        @(posedge clock); #1 in_fifo_out_nempty = 1'b0;
        wait_idle(ok);
        chk("full_idle", 32'(ok), 1);
        chk("full_pops", pop_cnt - p0, 2);
        chk("full_pushes", push_cnt - s0, 1);
        chk("full_aux_out", aux_out, 4'b1111);
        chk("full_aux_oe", aux_oe, 4'b1011);
        chk("push_while_full", bad_push, 0);

        // Reset in the middle of a long delay abandons it.
        @(posedge clock); #1;
        in_fifo_out_data = 16'h20FF; in_fifo_out_nempty = 1'b1;
        wait_pop(ok);
        chk("rdly_pop", 32'(ok), 1);
        @(posedge clock); #1 in_fifo_out_nempty = 1'b0;
        repeat (5) @(negedge clock);
        chk("rdly_busy_before", busy, 1);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        chk("rdly_busy", busy, 0);
        chk("rdly_aux_oe", aux_oe, 0);
        chk("rdly_aux_out", aux_out, 0);
        chk("rdly_error", error, 0);
        p0 = pop_cnt; s0 = push_cnt;
        repeat (5) @(negedge clock);
        #1;
        chk("rdly_no_pop", pop_cnt - p0, 0);
        chk("rdly_no_push", push_cnt - s0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
